// File: rtl/esp32_seq_pkg.sv
// -----------------------------------------------------------------------------
// esp32_seq_pkg
// Shared definitions for the ESP32 programming-entry sequencer.
//   seq_state_t        : sequencer state encoding (S_IDLE, S_RESET, S_STRAP)
//   PAIR_RUN/RST/BOOT  : {en,io0} pairs produced by the DTR/RTS decode
//   dtr_rts_to_en_io0  : maps the raw FTDI {ndtr,nrts} pin levels to {en,io0}
// -----------------------------------------------------------------------------
package esp32_seq_pkg;

  // State encoding is kept as plain constants so older tooling can read it.
  typedef logic [1:0] seq_state_t;

  localparam seq_state_t S_IDLE  = 2'd0;
  localparam seq_state_t S_RESET = 2'd1;
  localparam seq_state_t S_STRAP = 2'd2;

  // {en,io0} pairs
  localparam logic [1:0] PAIR_RUN  = 2'b11;
  localparam logic [1:0] PAIR_RST  = 2'b01;
  localparam logic [1:0] PAIR_BOOT = 2'b10;

  // Raw pin levels {ndtr,nrts}: RTS alone asserted holds EN low, DTR alone
  // asserted pulls IO0 low; both or neither asserted means run.
  function automatic logic [1:0] dtr_rts_to_en_io0(input logic [1:0] dtr_rts);
    logic [1:0] en_io0;
    case (dtr_rts)
      2'b10:   en_io0 = PAIR_RST;
      2'b01:   en_io0 = PAIR_BOOT;
      default: en_io0 = PAIR_RUN;
    endcase
    return en_io0;
  endfunction

endpackage

// File: rtl/esp32_seq_sync.sv
// -----------------------------------------------------------------------------
// esp32_seq_sync
// Synchronises the asynchronous FTDI {ndtr,nrts} pair, decodes it to {en,io0}
// and accepts the decoded pair only after it has been unchanged for
// FILTER_CYC consecutive cycles.
// Ports:
//   clk_25mhz   in   1  main clock
//   resetn      in   1  asynchronous active-low reset
//   dtr_rts     in   2  raw {ftdi_ndtr, ftdi_nrts}, asynchronous
//   stable_pair out  2  filtered {en,io0}, registered
// -----------------------------------------------------------------------------
module esp32_seq_sync
  import esp32_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 4
) (
  input  logic       clk_25mhz,
  input  logic       resetn,
  input  logic [1:0] dtr_rts,
  output logic [1:0] stable_pair
);

  localparam int               CNT_W   = $clog2(FILTER_CYC + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(FILTER_CYC);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1'b1);

  logic [SYNC_STAGES-1:0][1:0] sync_r;
  logic [1:0]                  decoded_s;
  logic [1:0]                  hold_r;
  logic [CNT_W-1:0]            run_r;
  logic [CNT_W-1:0]            run_s;
  logic [1:0]                  stable_r;

  // Shift register synchroniser, pins idle high.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      sync_r <= {SYNC_STAGES{2'b11}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], dtr_rts};
    end
  end

  // Filtering the decoded pair (not the raw pins) means 00<->11 toggling is
  // invisible, since both decode to the same run pair.
  assign decoded_s = dtr_rts_to_en_io0(sync_r[SYNC_STAGES-1]);

  // Length of the current run of identical decoded samples, including this one.
  always_comb begin
    run_s = run_r;
    if (decoded_s != hold_r) begin
      run_s = RUN_ONE;
    end else if (run_r == RUN_MAX) begin
      run_s = RUN_MAX;
    end else begin
      run_s = run_r + RUN_ONE;
    end
  end

  // Run tracking and acceptance of the decoded pair.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      hold_r   <= PAIR_RUN;
      run_r    <= {CNT_W{1'b0}};
      stable_r <= PAIR_RUN;
    end else begin
      hold_r <= decoded_s;
      run_r  <= run_s;
      if (run_s == RUN_MAX) begin
        stable_r <= decoded_s;
      end else begin
        stable_r <= stable_r;
      end
    end
  end

  assign stable_pair = stable_r;

endmodule

// File: rtl/esp32_prog_sequencer.sv
// -----------------------------------------------------------------------------
// esp32_prog_sequencer
// Sequences ESP32 programming entry from the FTDI DTR/RTS lines. Drives the
// ESP32 EN/GPIO0 from registers and owns a timed strap window on sd_d[0]
// (ESP32 GPIO2). Optionally raises a PROGRAMN multiboot request after a
// two-button hold.
// Build option: define ESP32_SEQ_MULTIBOOT_EN to enable the PROGRAMN
// generator; otherwise user_programn is tied high and btn_multi is ignored.
// Ports:
//   clk_25mhz     in   1  main clock, 25 MHz
//   resetn        in   1  asynchronous active-low reset
//   ftdi_ndtr     in   1  FTDI DTR, asynchronous, idle high
//   ftdi_nrts     in   1  FTDI RTS, asynchronous, idle high
//   btn_boot_n    in   1  BTN0, active-low, asynchronous
//   btn_multi     in   1  BTN1, active-high, asynchronous
//   wifi_en       out  1  ESP32 EN, registered
//   wifi_gpio0    out  1  ESP32 GPIO0, registered (BTN0 low forces it low)
//   strap_oe      out  1  1 = drive sd_d[0] with strap_val, 0 = tristate
//   strap_val     out  1  strap level for sd_d[0]
//   prog_active   out  1  1 while the sequencer is not idle
//   user_programn out  1  active-low PROGRAMN request
// -----------------------------------------------------------------------------
module esp32_prog_sequencer
  import esp32_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYC     = 4,
  parameter int TIMEOUT_LOG2   = 17,
  parameter int MULTIBOOT_LOG2 = 7
) (
  input  logic clk_25mhz,
  input  logic resetn,
  input  logic ftdi_ndtr,
  input  logic ftdi_nrts,
  input  logic btn_boot_n,
  input  logic btn_multi,
  output logic wifi_en,
  output logic wifi_gpio0,
  output logic strap_oe,
  output logic strap_val,
  output logic prog_active,
  output logic user_programn
);

  localparam int WIN_W = TIMEOUT_LOG2 + 1;

  logic [1:0]             stable_s;
  logic [SYNC_STAGES-1:0] boot_sync_r;
  logic                   btn_boot_sync_s;

  logic                   wifi_en_r;
  logic                   wifi_gpio0_r;

  seq_state_t             state_r;
  seq_state_t             state_nxt_s;
  logic [WIN_W-1:0]       win_r;
  logic [WIN_W-1:0]       win_inc_s;
  logic [WIN_W-1:0]       win_nxt_s;
  logic                   strap_oe_r;
  logic                   strap_val_r;
  logic                   strap_oe_nxt_s;
  logic                   strap_val_nxt_s;
  logic                   prog_active_r;

  esp32_seq_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_CYC  (FILTER_CYC)
  ) u_dtr_rts_sync (
    .clk_25mhz   (clk_25mhz),
    .resetn      (resetn),
    .dtr_rts     ({ftdi_ndtr, ftdi_nrts}),
    .stable_pair (stable_s)
  );

  // BTN0 synchroniser; the button is level-sensitive so no filter is needed.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      boot_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      boot_sync_r <= {boot_sync_r[SYNC_STAGES-2:0], btn_boot_n};
    end
  end

  assign btn_boot_sync_s = boot_sync_r[SYNC_STAGES-1];

  // EN/GPIO0 pin registers; BTN0 overrides GPIO0 regardless of state.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      wifi_en_r    <= 1'b1;
      wifi_gpio0_r <= 1'b1;
    end else begin
      wifi_en_r    <= stable_s[1];
      wifi_gpio0_r <= stable_s[0] & btn_boot_sync_s;
    end
  end

  // The window counter only ever holds values below 2^TIMEOUT_LOG2: expiry
  // is detected on the incremented value, so the top bit never gets stored.
  assign win_inc_s = win_r + WIN_W'(1'b1);

  // Next-state, window and strap pad decisions.
  always_comb begin
    state_nxt_s = state_r;
    win_nxt_s   = {WIN_W{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (stable_s == PAIR_RST) begin
          state_nxt_s = S_RESET;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RESET: begin
        if (stable_s == PAIR_BOOT) begin
          state_nxt_s = S_STRAP;
        end else if (stable_s == PAIR_RUN) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESET;
        end
      end
      S_STRAP: begin
        // A new reset request wins over a window expiring in the same cycle.
        if (stable_s == PAIR_RST) begin
          state_nxt_s = S_RESET;
        end else if (win_inc_s[TIMEOUT_LOG2]) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_STRAP;
          win_nxt_s   = win_inc_s;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase

    // Strap pad follows the next state so it switches with the state register.
    if (state_nxt_s == S_STRAP) begin
      strap_oe_nxt_s  = 1'b1;
      strap_val_nxt_s = stable_s[0];
    end else begin
      strap_oe_nxt_s  = 1'b0;
      strap_val_nxt_s = 1'b1;
    end
  end

  // Sequencer state, window counter and strap/status output registers.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      state_r       <= S_IDLE;
      win_r         <= {WIN_W{1'b0}};
      strap_oe_r    <= 1'b0;
      strap_val_r   <= 1'b1;
      prog_active_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      win_r         <= win_nxt_s;
      strap_oe_r    <= strap_oe_nxt_s;
      strap_val_r   <= strap_val_nxt_s;
      prog_active_r <= (state_nxt_s != S_IDLE);
    end
  end

`ifdef ESP32_SEQ_MULTIBOOT_EN
  localparam int MB_W = MULTIBOOT_LOG2 + 1;

  logic [SYNC_STAGES-1:0] multi_sync_r;
  logic                   btn_multi_sync_s;
  logic                   mb_hold_s;
  logic [MB_W-1:0]        mb_cnt_r;
  logic                   programn_r;

  // BTN1 synchroniser.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      multi_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      multi_sync_r <= {multi_sync_r[SYNC_STAGES-2:0], btn_multi};
    end
  end

  assign btn_multi_sync_s = multi_sync_r[SYNC_STAGES-1];

  // Both buttons held while no programming sequence is in flight.
  assign mb_hold_s = ~btn_boot_sync_s & btn_multi_sync_s & ~prog_active_r;

  // Hold counter saturating at 2^MULTIBOOT_LOG2, and the PROGRAMN register.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      mb_cnt_r   <= {MB_W{1'b0}};
      programn_r <= 1'b1;
    end else begin
      if (!mb_hold_s) begin
        mb_cnt_r <= {MB_W{1'b0}};
      end else if (mb_cnt_r[MULTIBOOT_LOG2]) begin
        mb_cnt_r <= mb_cnt_r;
      end else begin
        mb_cnt_r <= mb_cnt_r + MB_W'(1'b1);
      end
      programn_r <= ~mb_cnt_r[MULTIBOOT_LOG2];
    end
  end

  assign user_programn = programn_r;
`else
  // btn_multi and the hold length have no function in this build.
  logic [MULTIBOOT_LOG2:0] unused_mb_s;
  assign unused_mb_s   = {(MULTIBOOT_LOG2 + 1){btn_multi}};
  assign user_programn = 1'b1;
`endif

  assign wifi_en     = wifi_en_r;
  assign wifi_gpio0  = wifi_gpio0_r;
  assign strap_oe    = strap_oe_r;
  assign strap_val   = strap_val_r;
  assign prog_active = prog_active_r;

endmodule

// File: tb/tb_esp32_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_esp32_prog_sequencer
// Directed scenarios plus randomized pin/button activity for
// esp32_prog_sequencer, compared every cycle against a cycle-level reference
// model written from the behavioural rules (pin history, run-of-samples
// filter, strap window measured from its start cycle).
// Honours ESP32_SEQ_MULTIBOOT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_esp32_prog_sequencer;

  localparam int SYNC    = 2;
  localparam int FILT    = 4;
  localparam int TLOG    = 4;
  localparam int MLOG    = 3;
  localparam int WINDOW  = 1 << TLOG;
  localparam int MB_HOLD = 1 << MLOG;

  logic clk_25mhz  = 1'b0;
  logic resetn     = 1'b0;
  logic ftdi_ndtr  = 1'b1;
  logic ftdi_nrts  = 1'b1;
  logic btn_boot_n = 1'b1;
  logic btn_multi  = 1'b0;
  logic wifi_en, wifi_gpio0, strap_oe, strap_val, prog_active, user_programn;

  always #20 clk_25mhz = ~clk_25mhz;

  esp32_prog_sequencer #(
    .SYNC_STAGES    (SYNC),
    .FILTER_CYC     (FILT),
    .TIMEOUT_LOG2   (TLOG),
    .MULTIBOOT_LOG2 (MLOG)
  ) dut (
    .clk_25mhz     (clk_25mhz),
    .resetn        (resetn),
    .ftdi_ndtr     (ftdi_ndtr),
    .ftdi_nrts     (ftdi_nrts),
    .btn_boot_n    (btn_boot_n),
    .btn_multi     (btn_multi),
    .wifi_en       (wifi_en),
    .wifi_gpio0    (wifi_gpio0),
    .strap_oe      (strap_oe),
    .strap_val     (strap_val),
    .prog_active   (prog_active),
    .user_programn (user_programn)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_HELD, M_STRAP} m_phase_t;

  logic [1:0] m_pin_q[$];
  logic       m_boot_q[$];
  logic       m_multi_q[$];
  logic [1:0] m_dec_q[$];
  logic [1:0] m_stable;
  m_phase_t   m_phase;
  int         m_cycle;
  int         m_strap_start;
  int         m_hold;
  logic e_en, e_io0, e_oe, e_val, e_act, e_pgm;

  // EN is held low only when RTS alone is asserted; IO0 only when DTR alone is.
  function automatic logic [1:0] ref_en_io0(input logic [1:0] pins);
    logic rts_only, dtr_only;
    rts_only = pins[1] & ~pins[0];
    dtr_only = ~pins[1] & pins[0];
    return {~rts_only, ~dtr_only};
  endfunction

  task automatic model_reset();
    m_pin_q = {}; m_boot_q = {}; m_multi_q = {}; m_dec_q = {};
    for (int i = 0; i < SYNC; i++) begin
      m_pin_q.push_back(2'b11);
      m_boot_q.push_back(1'b1);
      m_multi_q.push_back(1'b1);
    end
    m_stable = 2'b11; m_phase = M_IDLE; m_cycle = 0; m_strap_start = 0; m_hold = 0;
    e_en = 1'b1; e_io0 = 1'b1; e_oe = 1'b0; e_val = 1'b1; e_act = 1'b0; e_pgm = 1'b1;
  endtask

  task automatic model_step();
    logic [1:0] seen, d, st_old;
    logic boot_s, multi_s, same;
    if (!resetn) begin
      model_reset();
      return;
    end
    m_cycle++;
    seen    = m_pin_q.pop_front();  m_pin_q.push_back({ftdi_ndtr, ftdi_nrts});
    boot_s  = m_boot_q.pop_front(); m_boot_q.push_back(btn_boot_n);
    multi_s = m_multi_q.pop_front(); m_multi_q.push_back(btn_multi);
    st_old  = m_stable;
    e_en  = st_old[1];
    e_io0 = st_old[0] & boot_s;
`ifdef ESP32_SEQ_MULTIBOOT_EN
    e_pgm = !(m_hold >= MB_HOLD);
    if (!boot_s && multi_s && !e_act) m_hold++;
    else m_hold = 0;
`else
    e_pgm = 1'b1;
`endif
    case (m_phase)
      M_IDLE:  if (st_old == 2'b01) m_phase = M_HELD;
      M_HELD: begin
        if (st_old == 2'b10) begin
          m_phase = M_STRAP;
          m_strap_start = m_cycle;
        end else if (st_old == 2'b11) m_phase = M_IDLE;
      end
      M_STRAP: begin
        if (st_old == 2'b01) m_phase = M_HELD;
        else if (m_cycle - m_strap_start >= WINDOW) m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
    e_act = (m_phase != M_IDLE);
    e_oe  = (m_phase == M_STRAP);
    e_val = (m_phase == M_STRAP) ? st_old[0] : 1'b1;
    // Accept the decoded pair once the last FILT samples all agree.
    d = ref_en_io0(seen);
    m_dec_q.push_back(d);
    if (m_dec_q.size() > FILT) m_dec_q.delete(0);
    same = (m_dec_q.size() == FILT);
    foreach (m_dec_q[i]) if (m_dec_q[i] != d) same = 1'b0;
    if (same) m_stable = d;
  endtask

  task automatic compare_all();
    check_val("wifi_en",       wifi_en,       e_en);
    check_val("wifi_gpio0",    wifi_gpio0,    e_io0);
    check_val("strap_oe",      strap_oe,      e_oe);
    check_val("strap_val",     strap_val,     e_val);
    check_val("prog_active",   prog_active,   e_act);
    check_val("user_programn", user_programn, e_pgm);
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic hold_pins(input logic [1:0] p, input int n);
    {ftdi_ndtr, ftdi_nrts} = p;
    repeat (n) tick();
  endtask

  // Reset request then boot request; returns on the edge the window opens.
  task automatic enter_strap();
    hold_pins(2'b10, 12);
    {ftdi_ndtr, ftdi_nrts} = 2'b01;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (strap_oe) break;
    end
    check_val("strap_entry", strap_oe, 1'b1);
  endtask

  task automatic async_reset(input int cycles);
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) tick();
    resetn = 1'b1;
  endtask

  initial begin
    int first_low, oe_cnt, oe_low_cnt, en_low_cnt, act_cnt, pgm_low_cnt;
    model_reset();
    repeat (3) tick();
    resetn = 1'b1;
    repeat (5) tick();
    check_val("rst_wifi_en", wifi_en, 1'b1);
    check_val("rst_gpio0", wifi_gpio0, 1'b1);
    check_val("rst_strap_oe", strap_oe, 1'b0);
    check_val("rst_programn", user_programn, 1'b1);
    check_val("rst_active", prog_active, 1'b0);

    // esptool sequence
    first_low = -1;
    {ftdi_ndtr, ftdi_nrts} = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!wifi_en && first_low < 0) first_low = i;
    end
    check_val("en_fall_latency", first_low, 7);
    oe_cnt = 0; oe_low_cnt = 0;
    {ftdi_ndtr, ftdi_nrts} = 2'b01;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) {ftdi_ndtr, ftdi_nrts} = 2'b11;
      tick();
      if (strap_oe) oe_cnt++;
      if (strap_oe && !strap_val) oe_low_cnt++;
    end
    check_val("strap_cycles", oe_cnt, WINDOW);
    check_val("strap_low_cycles", oe_low_cnt, WINDOW);
    check_val("esptool_end_oe", strap_oe, 1'b0);
    check_val("esptool_end_active", prog_active, 1'b0);

    // short glitch must be ignored
    hold_pins(2'b10, 2);
    en_low_cnt = 0; act_cnt = 0;
    {ftdi_ndtr, ftdi_nrts} = 2'b11;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!wifi_en) en_low_cnt++;
      if (prog_active) act_cnt++;
    end
    check_val("glitch_en", en_low_cnt, 0);
    check_val("glitch_active", act_cnt, 0);

    // reset request arriving on the expiry cycle wins
    enter_strap();
    repeat (9) tick();
    {ftdi_ndtr, ftdi_nrts} = 2'b10;
    repeat (7) tick();
    check_val("prio_oe", strap_oe, 1'b0);
    check_val("prio_no_idle", prog_active, 1'b1);
    hold_pins(2'b10, 5);
    hold_pins(2'b11, 15);
    check_val("prio_back_idle", prog_active, 1'b0);

    // asynchronous reset in the middle of the window
    enter_strap();
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check_val("areset_en", wifi_en, 1'b1);
    check_val("areset_gpio0", wifi_gpio0, 1'b1);
    check_val("areset_oe", strap_oe, 1'b0);
    check_val("areset_val", strap_val, 1'b1);
    check_val("areset_active", prog_active, 1'b0);
    check_val("areset_programn", user_programn, 1'b1);
    model_reset();
    {ftdi_ndtr, ftdi_nrts} = 2'b11;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (8) tick();

    // multiboot button hold while idle
    first_low = -1;
    btn_boot_n = 1'b0; btn_multi = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!user_programn && first_low < 0) first_low = i;
    end
`ifdef ESP32_SEQ_MULTIBOOT_EN
    check_val("mb_latency", first_low, SYNC + MB_HOLD + 1);
`else
    check_val("mb_never", first_low, -1);
`endif
    btn_boot_n = 1'b1; btn_multi = 1'b0;
    repeat (5) tick();
    check_val("mb_release", user_programn, 1'b1);

    // same hold during the strap window has no effect
    enter_strap();
    btn_boot_n = 1'b0; btn_multi = 1'b1;
    pgm_low_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (!user_programn) pgm_low_cnt++;
    end
    check_val("mb_in_strap", pgm_low_cnt, 0);
    btn_boot_n = 1'b1; btn_multi = 1'b0;
    hold_pins(2'b01, 10);
    hold_pins(2'b11, 20);

    // randomized activity
    for (int seg = 0; seg < 300; seg++) begin
      btn_boot_n = ($urandom_range(0, 5) != 0);
      btn_multi  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) async_reset(2);
      hold_pins(2'($urandom_range(0, 3)), $urandom_range(1, 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
